// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: main pipeline (A) preferred, long-latency unit (B) protected by a starvation counter.
// Optional combinational bypass of the registered write stage when WPORT_BYPASS_EN is defined.
module rf_wport_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
`ifdef WPORT_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] byp_q_a,
    input  logic [ADDR_W-1:0] byp_q_b,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       stage_valid;
    logic [3:0] starve_cnt;
    logic       b_forced;

    // B overrides A only once it has been refused STARVE_MAX times in a row
    always_comb begin
        b_forced = (starve_cnt >= STARVE_LIM);
        a_ready  = en && a_valid && !(b_valid && b_forced);
        b_ready  = en && b_valid && !(a_valid && !b_forced);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
        end else if (en) begin
            if (a_ready) begin
                stage_valid <= 1'b1;
                rf_addr     <= a_addr;
                rf_data     <= a_data;
            end else if (b_ready) begin
                stage_valid <= 1'b1;
                rf_addr     <= b_addr;
                rf_data     <= b_data;
            end else begin
                stage_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (en) begin
            if (b_valid && !b_ready)
                starve_cnt <= b_forced ? STARVE_LIM : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;
        end
    end

    always_comb begin
        rf_en = en;
        rf_we = stage_valid;
    end

`ifdef WPORT_BYPASS_EN
    always_comb begin
        byp_hit_a = stage_valid && (rf_addr != '0) && (rf_addr == byp_q_a);
        byp_hit_b = stage_valid && (rf_addr != '0) && (rf_addr == byp_q_b);
        byp_data  = rf_data;
    end
`endif

endmodule
